sr_bank_sched: RTL and testbench
================================

// Module: sr_bank_sched
// PURPOSE
//  Shares one bank of NBITS edge-triggered SR flip-flops (status flags) between NREQ requesters.
//  Round-robin arbiter plus sequencer: grants one requester, drives exactly one s or r line for
//  one cycle, reads the flag back and reports completion. Guarantees the forbidden s=r=1
//  excitation never reaches the bank. Sits between the control FSMs and the flag bank.
// PARAMETERS
//  NREQ      4   number of requesters (2..8)
//  NBITS     8   number of SR flip-flops in the bank (2..16)
//  IDXW      3   index width, >= clog2(NBITS)
//  MAXRETRY  2   extra drive attempts after a failed read-back (0..7)
// PORTS
//  ck       in   1          clock, all state updates on rising edge
//  rst_n    in   1          asynchronous reset, active low
//  req      in   NREQ       request per requester; held until its done
//  cmd_set  in   NREQ       per requester: 1 = set flag, 0 = reset flag
//  cmd_idx  in   NREQ*IDXW  per requester flag index, requester i at [i*IDXW +: IDXW]
//  q        in   NBITS      read-back of bank state
//  s        out  NBITS      set excitation to bank, registered
//  r        out  NBITS      reset excitation to bank, registered
//  gnt      out  NREQ       one-hot grant, registered, held DRIVE..DONE
//  done     out  1          one-cycle completion pulse for granted requester
//  ok       out  1          valid with done: 1 = flag verified, 0 = failed/illegal
//  err      out  1          sticky: any failed operation since reset
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, ptr=0, retry=0; s=r=gnt=0, done=ok=err=0.
//    s/r drop immediately on reset assertion, even mid-DRIVE.
//  - FSM: IDLE -> DRIVE -> VERIFY -> DONE -> IDLE; VERIFY -> DRIVE on retry.
//  - IDLE: if |req, latch winner w = first requester with req=1 at or after ptr (wrapping),
//    latch cmd_set[w] and cmd_idx[w]; gnt<=onehot(w); retry<=0; go DRIVE.
//    If the latched idx >= NBITS: no drive, go straight to DONE with ok=0, err<=1.
//  - DRIVE (1 cycle): s[idx]=1 if set else r[idx]=1; all other s/r bits 0. Go VERIFY.
//  - VERIFY (1 cycle): s=r=0. If q[idx]==set: go DONE with ok=1.
//    Otherwise, if retry<MAXRETRY: retry++ and go DRIVE; else go DONE with ok=0, err<=1.
//  - DONE (1 cycle): done=1, gnt held, ok valid. ptr<=w+1 (mod NREQ). Go IDLE; gnt<=0.
//  - Latency: req seen in cycle 0 -> DRIVE in cycle 1 -> VERIFY in cycle 2 -> done in cycle 3.
//    Each retry adds 2 cycles. Back-to-back operations: one IDLE cycle between them.
//  - Invariants: popcount(s|r)<=1 and (s&r)==0 in every cycle; gnt one-hot or zero.
//  - The command is latched at grant. If the requester drops req or changes cmd mid-operation,
//    the operation still completes unchanged. Requester must deassert req in the cycle after done,
//    or it is eligible again.
//  - Simultaneous requests: strict round-robin; the last-served requester has lowest priority next.
//  - Set on an already-set flag (or reset on a clear one) is legal: drive anyway, ok=1.
//  - err is cleared only by rst_n.
// STRUCTURE
//  - Shared header sr_sched_defs.vh: state encodings (IDLE=0, DRIVE=1, VERIFY=2, DONE=3) and
//    parameter range checks.
//  - One sub-module, rr_arbiter (NREQ): inputs req and ptr; outputs one-hot winner and its
//    binary index. Purely combinational.
//  - Top holds the FSM, ptr, retry counter, latched command and the registered s/r/gnt/done/ok/err.
// TESTING
//  1. Reset: drive rst_n=0 mid-DRIVE with s[3]=1 -> s,r,gnt,done,ok,err all 0 at once; FSM in IDLE.
//  2. Single set: req=0001, cmd_set[0]=1, idx0=5, bank model updates q -> s=0x20 in cycle 1,
//     done=1 with ok=1 in cycle 3, gnt=0001 over cycles 1..3.
//  3. Round-robin: req=1111 held, each requester releases after its done ->
//     grant order 0,1,2,3,0; never s&r!=0.
//  4. Stuck flag: bank model ignores r[2], reset idx 2 with MAXRETRY=2 -> three r[2] pulses,
//     done with ok=0, err=1 and stays 1.
//  5. Illegal index: NBITS=6, idx=7 -> no s/r activity, done in cycle 1 after grant, ok=0, err=1.
//  6. Mid-op change: change cmd_set/idx and drop req during VERIFY ->
//     operation completes on the original idx, ok=1.

Source files
------------

// File: rtl/sr_bank_sched_pkg.sv
// sr_bank_sched_pkg: FSM encodings and shared widths for the SR bank scheduler
package sr_bank_sched_pkg;
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE   = 2'd0;
   localparam state_t ST_DRIVE  = 2'd1;
   localparam state_t ST_VERIFY = 2'd2;
   localparam state_t ST_DONE   = 2'd3;
   localparam int RETRY_W = 3;
endpackage

// File: rtl/sr_bank_sched_rr_arbiter.sv
// sr_bank_sched_rr_arbiter: combinational round-robin pick starting at ptr
module sr_bank_sched_rr_arbiter #(
   parameter int NREQ = 4,
   parameter int PW   = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [NREQ-1:0] win,
   output logic [PW-1:0]   idx
);
   logic [PW-1:0] j;
   // scan offsets from farthest to nearest so the first requester at/after ptr wins last
   always_comb begin
      win = '0;
      idx = '0;
      j = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         j = PW'((int'(ptr) + k) % NREQ);
         if (req[j]) begin
            win = '0;
            win[j] = 1'b1;
            idx = j;
         end
      end
   end
endmodule

// File: rtl/sr_bank_sched.sv
// sr_bank_sched: round-robin sequencer driving one s/r pulse per grant with read-back and retry
module sr_bank_sched
   import sr_bank_sched_pkg::*;
#(
   parameter int NREQ     = 4,
   parameter int NBITS    = 8,
   parameter int IDXW     = 3,
   parameter int MAXRETRY = 2
) (
   input  logic                 ck,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ-1:0]      cmd_set,
   input  logic [NREQ*IDXW-1:0] cmd_idx,
   input  logic [NBITS-1:0]     q,
   output logic [NBITS-1:0]     s,
   output logic [NBITS-1:0]     r,
   output logic [NREQ-1:0]      gnt,
   output logic                 done,
   output logic                 ok,
   output logic                 err
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   state_t             state;
   logic [PW-1:0]      ptr, widx, arb_idx;
   logic [NREQ-1:0]    arb_win;
   logic [RETRY_W-1:0] retry;
   logic               lset, c_set, c_legal, q_hit;
   logic [IDXW-1:0]    lidx, c_idx;
   logic [NBITS-1:0]   lmask, c_mask;
   sr_bank_sched_rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
      .req(req),
      .ptr(ptr),
      .win(arb_win),
      .idx(arb_idx)
   );
   assign c_set   = cmd_set[arb_idx];
   assign c_idx   = cmd_idx[int'(arb_idx)*IDXW +: IDXW];
   assign c_legal = int'(c_idx) < NBITS;
   assign c_mask  = NBITS'(1) << c_idx;
   assign lmask   = NBITS'(1) << lidx;
   assign q_hit   = ((q & lmask) != '0) == lset;
   // sequencer: grant, single-line drive, read-back with bounded retry, completion report
   always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         ptr   <= '0;
         widx  <= '0;
         retry <= '0;
         lset  <= 1'b0;
         lidx  <= '0;
         s     <= '0;
         r     <= '0;
         gnt   <= '0;
         done  <= 1'b0;
         ok    <= 1'b0;
         err   <= 1'b0;
      end else begin
         s    <= '0;
         r    <= '0;
         done <= 1'b0;
         case (state)
            ST_IDLE: if (|req) begin
               widx  <= arb_idx;
               lset  <= c_set;
               lidx  <= c_idx;
               gnt   <= arb_win;
               retry <= '0;
               if (c_legal) begin
                  state <= ST_DRIVE;
                  s     <= c_set ? c_mask : '0;
                  r     <= c_set ? '0 : c_mask;
               end else begin
                  state <= ST_DONE;
                  done  <= 1'b1;
                  ok    <= 1'b0;
                  err   <= 1'b1;
               end
            end
            ST_DRIVE: state <= ST_VERIFY;
            ST_VERIFY: if (q_hit) begin
               state <= ST_DONE;
               done  <= 1'b1;
               ok    <= 1'b1;
            end else if (int'(retry) < MAXRETRY) begin
               state <= ST_DRIVE;
               retry <= retry + RETRY_W'(1);
               s     <= lset ? lmask : '0;
               r     <= lset ? '0 : lmask;
            end else begin
               state <= ST_DONE;
               done  <= 1'b1;
               ok    <= 1'b0;
               err   <= 1'b1;
            end
            ST_DONE: begin
               state <= ST_IDLE;
               gnt   <= '0;
               ok    <= 1'b0;
               ptr   <= (int'(widx) == NREQ - 1) ? '0 : widx + PW'(1);
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sr_bank_sched.sv
// tb_sr_bank_sched: directed stimulus with a per-operation trace model and literal pins
module tb_sr_bank_sched;
   localparam int NREQ = 4, NBITS = 6, IDXW = 3, MAXRETRY = 2;
   logic ck = 1'b0, rst_n;
   logic [NREQ-1:0] req, cmd_set, gnt;
   logic [NREQ*IDXW-1:0] cmd_idx;
   logic [NBITS-1:0] q_bank = '0, stuck, s, r;
   logic done, ok, err;
   int checks = 0, failures = 0;
   typedef struct {logic [NBITS-1:0] s, r; logic [NREQ-1:0] g; bit d, ok;} exp_t;
   exp_t qx[$];
   exp_t e;
   bit errm;
   int ptrm;
   sr_bank_sched #(.NREQ(NREQ), .NBITS(NBITS), .IDXW(IDXW), .MAXRETRY(MAXRETRY)) dut (
      .ck(ck), .rst_n(rst_n), .req(req), .cmd_set(cmd_set), .cmd_idx(cmd_idx), .q(q_bank),
      .s(s), .r(r), .gnt(gnt), .done(done), .ok(ok), .err(err)
   );
   always #5 ck = ~ck;
   // flag bank: set wins, reset ignored on stuck bits
   always @(posedge ck)
      for (int b = 0; b < NBITS; b++)
         if (s[b]) q_bank[b] <= 1'b1;
         else if (r[b] && !stuck[b]) q_bank[b] <= 1'b0;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   // expand one granted operation into its expected per-cycle outputs
   task automatic build();
      int w = -1;
      bit cs, flag, hit;
      logic [IDXW-1:0] ci;
      logic [NBITS-1:0] m;
      logic [NREQ-1:0] g;
      for (int k = 0; k < NREQ; k++)
         if (w < 0 && req[(ptrm + k) % NREQ]) w = (ptrm + k) % NREQ;
      cs = cmd_set[w];
      ci = cmd_idx[w*IDXW +: IDXW];
      g = '0;
      g[w] = 1'b1;
      ptrm = (w + 1) % NREQ;
      if (int'(ci) >= NBITS) begin
         qx.push_back('{'0, '0, g, 1, 0});
         return;
      end
      m = '0;
      m[ci] = 1'b1;
      flag = q_bank[ci];
      hit = 0;
      for (int a = 0; a <= MAXRETRY && !hit; a++) begin
         qx.push_back('{cs ? m : '0, cs ? '0 : m, g, 0, 0});
         qx.push_back('{'0, '0, g, 0, 0});
         flag = cs ? 1'b1 : (stuck[ci] ? flag : 1'b0);
         hit = (flag == cs);
      end
      qx.push_back('{'0, '0, g, 1, hit});
   endtask
   // every-cycle comparison against the trace model
   always @(negedge ck) begin
      if (!rst_n) begin
         qx.delete();
         errm = 0;
         ptrm = 0;
         e = '{'0, '0, '0, 0, 0};
      end else if (qx.size() != 0) e = qx.pop_front();
      else begin
         e = '{'0, '0, '0, 0, 0};
         if (req != '0) build();
      end
      if (e.d && !e.ok) errm = 1;
      chk("s", 32'(s), 32'(e.s));
      chk("r", 32'(r), 32'(e.r));
      chk("gnt", 32'(gnt), 32'(e.g));
      chk("done", 32'(done), 32'(e.d));
      chk("err", 32'(err), 32'(errm));
      if (e.d) chk("ok", 32'(ok), 32'(e.ok));
      chk("s_and_r", 32'(s & r), 0);
      chk("one_hot_sr", 32'($countones(s | r) <= 1), 1);
   end
   task automatic op(input int k, input bit cs, input logic [IDXW-1:0] ci, input bit meddle,
                     output int lat, output bit okv, output logic [NBITS-1:0] s1, output int pulses);
      req[k] = 1'b1;
      cmd_set[k] = cs;
      cmd_idx[k*IDXW +: IDXW] = ci;
      lat = 0;
      pulses = 0;
      s1 = '0;
      okv = 0;
      while (lat < 40) begin
         @(posedge ck); #1;
         lat++;
         if (lat == 1) s1 = s;
         if ((s | r) != '0) pulses++;
         if (meddle && lat == 2) begin
            req[k] = 1'b0;
            cmd_set[k] = ~cs;
            cmd_idx[k*IDXW +: IDXW] = ci ^ 3'd1;
         end
         if (done) begin
            okv = ok;
            break;
         end
      end
      req[k] = 1'b0;
      if (!done) chk("op_timeout", 32'(lat), 0);
      @(posedge ck); #1;
   endtask
   int lat, pul, t, kk;
   bit okv;
   logic [NBITS-1:0] s1;
   logic [NREQ-1:0] order [5];
   initial begin
      rst_n = 1'b0;
      req = '0;
      cmd_set = '0;
      cmd_idx = '0;
      stuck = '0;
      repeat (3) @(posedge ck);
      #1;
      chk("rst_s", 32'(s), 0);
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_err", 32'(err), 0);
      rst_n = 1'b1;
      @(posedge ck); #1;
      req[3] = 1'b1;
      cmd_set[3] = 1'b1;
      cmd_idx[9 +: 3] = 3'd3;
      @(posedge ck); #1;
      chk("t1_s_drive", 32'(s), 32'h08);
      rst_n = 1'b0;
      #1;
      chk("t1_s_async", 32'(s), 0);
      chk("t1_r_async", 32'(r), 0);
      chk("t1_gnt_async", 32'(gnt), 0);
      chk("t1_done_ok_err", {29'd0, done, ok, err}, 0);
      req = '0;
      repeat (2) @(posedge ck);
      #1;
      rst_n = 1'b1;
      @(posedge ck); #1;
      op(0, 1, 3'd5, 0, lat, okv, s1, pul);
      chk("t2_s_cycle1", 32'(s1), 32'h20);
      chk("t2_latency", 32'(lat), 3);
      chk("t2_ok", 32'(okv), 1);
      chk("t2_flag", 32'(q_bank[5]), 1);
      rst_n = 1'b0;
      repeat (2) @(posedge ck);
      #1;
      rst_n = 1'b1;
      @(posedge ck); #1;
      cmd_set = '1;
      cmd_idx = {3'd3, 3'd2, 3'd1, 3'd0};
      req = '1;
      for (int n = 0; n < 5; n++) begin
         t = 0;
         while (!done && t < 20) begin
            @(posedge ck); #1;
            t++;
         end
         order[n] = done ? gnt : '0;
         kk = 0;
         for (int b = 0; b < NREQ; b++) if (gnt[b]) kk = b;
         req[kk] = 1'b0;
         repeat (2) @(posedge ck);
         #1;
         req[kk] = 1'b1;
      end
      req = '0;
      repeat (12) @(posedge ck);
      #1;
      chk("t3_order0", 32'(order[0]), 1);
      chk("t3_order1", 32'(order[1]), 2);
      chk("t3_order2", 32'(order[2]), 4);
      chk("t3_order3", 32'(order[3]), 8);
      chk("t3_order4", 32'(order[4]), 1);
      chk("t4_err_before", 32'(err), 0);
      stuck[2] = 1'b1;
      op(2, 0, 3'd2, 0, lat, okv, s1, pul);
      chk("t4_latency", 32'(lat), 7);
      chk("t4_pulses", 32'(pul), 3);
      chk("t4_ok", 32'(okv), 0);
      repeat (3) @(posedge ck);
      #1;
      chk("t4_err_sticky", 32'(err), 1);
      stuck = '0;
      op(1, 1, 3'd7, 0, lat, okv, s1, pul);
      chk("t5_latency", 32'(lat), 1);
      chk("t5_pulses", 32'(pul), 0);
      chk("t5_ok", 32'(okv), 0);
      chk("t5_err", 32'(err), 1);
      op(1, 1, 3'd4, 1, lat, okv, s1, pul);
      chk("t6_latency", 32'(lat), 3);
      chk("t6_ok", 32'(okv), 1);
      chk("t6_flag4", 32'(q_bank[4]), 1);
      chk("t6_flag5", 32'(q_bank[5]), 1);
      repeat (3) @(posedge ck);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
